// File: rtl/d_branch_seq_ctrl_if.sv
// d_branch_seq_ctrl_if: decode-side control bundle for the branch/jump sequencer
// master: decode stage, drives i_* requests and observes o_* pipeline controls
// slave : sequencer, consumes i_* and drives o_* (PC mux, stalls, flush, status, stats)
interface d_branch_seq_ctrl_if #(parameter int CNT_W = 32);
   logic             i_ifstall;
   logic [2:0]       i_bop;
   logic [1:0]       i_jump;
   logic             i_opnd_hazard;
   logic             i_taken;
   logic             i_mem_stall;
   logic             o_pc_stall;
   logic             o_ifid_stall;
   logic             o_ifid_flush;
   logic [1:0]       o_pc_sel;
   logic             o_busy;
   logic             o_timeout;
   logic [CNT_W-1:0] o_br_count;
   logic [CNT_W-1:0] o_taken_count;
   modport master (
      output i_ifstall, i_bop, i_jump, i_opnd_hazard, i_taken, i_mem_stall,
      input  o_pc_stall, o_ifid_stall, o_ifid_flush, o_pc_sel, o_busy, o_timeout,
             o_br_count, o_taken_count
   );
   modport slave (
      input  i_ifstall, i_bop, i_jump, i_opnd_hazard, i_taken, i_mem_stall,
      output o_pc_stall, o_ifid_stall, o_ifid_flush, o_pc_sel, o_busy, o_timeout,
             o_br_count, o_taken_count
   );
endinterface

// File: rtl/d_branch_seq_ctrl.sv
// d_branch_seq_ctrl: decode-stage branch/jump sequencer for the 5-stage MIPS pipeline
// i_clk, i_rst : clock (rising edge), synchronous active-high reset
// bus (slave)  : decode requests in; PC-mux select, PC/IF-ID stall, IF-ID flush,
//                busy, sticky timeout and branch statistics out
// BRANCH_STATS_EN: when defined, builds the resolved/taken branch counters;
//                  otherwise both count ports read 0
module d_branch_seq_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 32
) (
   input logic             i_clk,
   input logic             i_rst,
   d_branch_seq_ctrl_if.slave bus
);
   localparam int WW = $clog2(MAX_WAIT + 1);
   typedef enum logic [1:0] {IDLE, HOLD, RESOLVE} state_t;
   state_t          state, state_nx;
   logic            is_jr, is_jr_nx;
   logic [WW-1:0]   cnt, cnt_nx;
   logic            timeout, timeout_nx;
   logic            stall, flush;
   logic [1:0]      sel;
   logic            req, jmp;
   // i_ifstall takes priority, so a plain j/jal is only honoured without it
   assign req = (bus.i_ifstall && bus.i_bop != 3'd0) || bus.i_jump == 2'b10;
   assign jmp = !bus.i_ifstall && bus.i_jump == 2'b01;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         is_jr   <= 1'b0;
         cnt     <= '0;
         timeout <= 1'b0;
      end else if (!bus.i_mem_stall) begin
         state   <= state_nx;
         is_jr   <= is_jr_nx;
         cnt     <= cnt_nx;
         timeout <= timeout_nx;
      end
   end
   always_comb begin
      state_nx   = state;
      is_jr_nx   = is_jr;
      cnt_nx     = cnt;
      timeout_nx = timeout;
      stall      = 1'b0;
      flush      = 1'b0;
      sel        = 2'b00;
      unique case (state)
         IDLE: begin
            if (req) begin
               stall    = 1'b1;
               is_jr_nx = bus.i_jump == 2'b10 && !bus.i_ifstall;
               state_nx = bus.i_opnd_hazard ? HOLD : RESOLVE;
            end else if (jmp) begin
               sel   = 2'b10;
               flush = 1'b1;
            end
         end
         HOLD: begin
            stall = 1'b1;
            if (!bus.i_opnd_hazard) begin
               state_nx = RESOLVE;
               cnt_nx   = '0;
            end else if (cnt == WW'(MAX_WAIT - 1)) begin
               // this is the MAX_WAIT-th wait cycle: give up and resolve anyway
               timeout_nx = 1'b1;
               state_nx   = RESOLVE;
               cnt_nx     = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         RESOLVE: begin
            flush    = 1'b1;
            sel      = is_jr ? 2'b11 : {1'b0, bus.i_taken};
            state_nx = IDLE;
            is_jr_nx = 1'b0;
         end
         default: state_nx = IDLE;
      endcase
      // a memory stall freezes the front end; the redirect waits for it to clear
      if (bus.i_mem_stall) begin
         stall = 1'b1;
         flush = 1'b0;
         sel   = 2'b00;
      end
   end
   assign bus.o_pc_stall   = stall;
   assign bus.o_ifid_stall = stall;
   assign bus.o_ifid_flush = flush;
   assign bus.o_pc_sel     = sel;
   assign bus.o_busy       = state != IDLE;
   assign bus.o_timeout    = timeout;
`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] br_cnt, tk_cnt;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         br_cnt <= '0;
         tk_cnt <= '0;
      end else if (state == RESOLVE && !bus.i_mem_stall && !is_jr) begin
         br_cnt <= br_cnt + 1'b1;
         tk_cnt <= tk_cnt + CNT_W'(bus.i_taken);
      end
   end
   assign bus.o_br_count    = br_cnt;
   assign bus.o_taken_count = tk_cnt;
`else
   assign bus.o_br_count    = '0;
   assign bus.o_taken_count = '0;
`endif
endmodule

// File: tb/tb_d_branch_seq_ctrl.sv
// tb_d_branch_seq_ctrl: scoreboard bench for the branch/jump sequencer
module tb_d_branch_seq_ctrl;
`ifdef BRANCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   // expected output vector: {busy, timeout, pc_stall, ifid_stall, flush, pc_sel[1:0]}
   typedef struct {
      string       tag;
      logic [6:0]  o;
      logic [31:0] br;
      logic [31:0] tk;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] eb = 0;
   logic [31:0] et = 0;
   exp_t        q[$];
   d_branch_seq_ctrl_if #(.CNT_W(32)) bus ();
   d_branch_seq_ctrl #(.MAX_WAIT(15), .CNT_W(32)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.tag, {25'd0, bus.o_busy, bus.o_timeout, bus.o_pc_stall, bus.o_ifid_stall,
                     bus.o_ifid_flush, bus.o_pc_sel}, {25'd0, e.o});
         chk({e.tag, "_br"}, bus.o_br_count, e.br);
         chk({e.tag, "_tk"}, bus.o_taken_count, e.tk);
      end
   end
   // drive one cycle, queue its expected outputs, then apply the counter
   // effects (cb/ct) or reset (rs) that take hold after the clock edge
   task automatic step(input string tag, input logic ifs, input logic [2:0] bop,
                       input logic [1:0] jmp, input logic hz, input logic tk,
                       input logic ms, input logic rs, input logic [6:0] o,
                       input logic cb, input logic ct);
      exp_t e;
      bus.i_ifstall     = ifs;
      bus.i_bop         = bop;
      bus.i_jump        = jmp;
      bus.i_opnd_hazard = hz;
      bus.i_taken       = tk;
      bus.i_mem_stall   = ms;
      rst               = rs;
      e.tag = tag;
      e.o   = o;
      e.br  = eb;
      e.tk  = et;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (STATS && cb) eb++;
      if (STATS && ct) et++;
      if (rs) begin
         eb = 0;
         et = 0;
      end
   endtask
   task automatic idle(input string tag, input logic [6:0] o);
      step(tag, 1'b0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, o, 1'b0, 1'b0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
   initial begin
      bus.i_ifstall = 0; bus.i_bop = 0; bus.i_jump = 0;
      bus.i_opnd_hazard = 0; bus.i_taken = 0; bus.i_mem_stall = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) idle("rst_idle", 7'b0000000);
      // beq, no hazard, taken
      step("beq_c0", 1, 3'b001, 2'b00, 0, 0, 0, 0, 7'b0011000, 0, 0);
      step("beq_c1", 0, 3'b000, 2'b00, 0, 1, 0, 0, 7'b1000101, 1, 1);
      idle("beq_c2", 7'b0000000);
      // jr with operand hazard for 3 cycles
      step("jr_c0", 0, 3'b000, 2'b10, 1, 0, 0, 0, 7'b0011000, 0, 0);
      step("jr_c1", 0, 3'b000, 2'b00, 1, 0, 0, 0, 7'b1011000, 0, 0);
      step("jr_c2", 0, 3'b000, 2'b00, 1, 0, 0, 0, 7'b1011000, 0, 0);
      step("jr_c3", 0, 3'b000, 2'b00, 0, 0, 0, 0, 7'b1011000, 0, 0);
      step("jr_res", 0, 3'b000, 2'b00, 0, 1, 0, 0, 7'b1000111, 0, 0);
      idle("jr_done", 7'b0000000);
      // j: one-cycle redirect, no stall, stays idle
      step("j_c0", 0, 3'b000, 2'b01, 0, 0, 0, 0, 7'b0000110, 0, 0);
      idle("j_c1", 7'b0000000);
      // ifstall with j encoding: ifstall wins, resolves as branch not taken
      step("ill_c0", 1, 3'b001, 2'b01, 0, 0, 0, 0, 7'b0011000, 0, 0);
      step("ill_res", 0, 3'b000, 2'b00, 0, 0, 0, 0, 7'b1000100, 1, 0);
      idle("ill_done", 7'b0000000);
      // request during mem stall is ignored
      step("ms_req", 1, 3'b001, 2'b00, 0, 0, 1, 0, 7'b0011000, 0, 0);
      idle("ms_ign", 7'b0000000);
      // bgtz resolving under a 2-cycle mem stall
      step("bgtz_c0", 1, 3'b111, 2'b00, 0, 0, 0, 0, 7'b0011000, 0, 0);
      step("bgtz_ms1", 0, 3'b000, 2'b00, 0, 1, 1, 0, 7'b1011000, 0, 0);
      step("bgtz_ms2", 0, 3'b000, 2'b00, 0, 1, 1, 0, 7'b1011000, 0, 0);
      step("bgtz_res", 0, 3'b000, 2'b00, 0, 1, 0, 0, 7'b1000101, 1, 1);
      idle("bgtz_done", 7'b0000000);
      // reset while in HOLD discards the pending redirect
      step("rh_c0", 0, 3'b000, 2'b10, 1, 0, 0, 0, 7'b0011000, 0, 0);
      step("rh_c1", 0, 3'b000, 2'b00, 1, 0, 0, 0, 7'b1011000, 0, 0);
      step("rh_rst", 0, 3'b000, 2'b00, 1, 1, 0, 1, 7'b1011000, 0, 0);
      idle("rh_c3", 7'b0000000);
      idle("rh_c4", 7'b0000000);
      // bne with hazard stuck: 15 HOLD cycles then forced not-taken resolve
      step("to_c0", 1, 3'b010, 2'b00, 1, 0, 0, 0, 7'b0011000, 0, 0);
      for (int i = 0; i < 15; i++)
         step("to_hold", 0, 3'b000, 2'b00, 1, 1, 0, 0, 7'b1011000, 0, 0);
      step("to_res", 0, 3'b000, 2'b00, 1, 0, 0, 0, 7'b1100100, 1, 0);
      idle("to_sticky1", 7'b0100000);
      idle("to_sticky2", 7'b0100000);
      // reset clears sticky timeout and statistics
      step("to_rst", 0, 3'b000, 2'b00, 0, 0, 0, 1, 7'b0100000, 0, 0);
      idle("post_rst", 7'b0000000);
      @(negedge clk);
      chk("sb_drain", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
